// File: rtl/register_serializer.sv
// Parallel-in, serial-out shifter: LOAD captures a word, then one bit leaves per SVALID/SREADY beat.
// LOAD to DONE takes WIDTH+1 edges at full rate; SREADY=0 freezes the frame; all outputs are registered.
module register_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATAIN,
  output logic             READY,
  output logic             SOUT,
  output logic             SVALID,
  input  logic             SREADY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_d, sout_d, svalid_d, done_d;

  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Shift toward the output end, back-filling with zero.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          shreg_d = DATAIN;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (SREADY) begin
          shreg_d = shift_word(shreg_q);
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state will present.
    ready_d  = (state_d == S_IDLE);
    svalid_d = (state_d == S_SHIFT);
    done_d   = (state_d == S_DONE);
    sout_d   = svalid_d & out_bit(shreg_d);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      READY   <= 1'b1;
      SOUT    <= 1'b0;
      SVALID  <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      READY   <= ready_d;
      SOUT    <= sout_d;
      SVALID  <= svalid_d;
      DONE    <= done_d;
    end
  end

endmodule

// File: tb/tb_register_serializer.sv
// Directed bench for register_serializer: MSB-first and LSB-first instances on one clock and reset.
module tb_register_serializer;

  logic        CLOCK = 1'b0;
  logic        RESET, LOAD, SREADY;
  logic [15:0] DATAIN;
  logic        READY, SOUT, SVALID, DONE;

  logic        load_l, sready_l;
  logic [15:0] datain_l;
  logic        ready_l, sout_l, svalid_l, done_l;

  int n_checks = 0;
  int n_fail = 0;
  int done_pulses = 0;

  always #5 CLOCK = ~CLOCK;

  register_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
    .CLOCK(CLOCK), .RESET(RESET), .LOAD(LOAD), .DATAIN(DATAIN), .READY(READY),
    .SOUT(SOUT), .SVALID(SVALID), .SREADY(SREADY), .DONE(DONE)
  );

  register_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
    .CLOCK(CLOCK), .RESET(RESET), .LOAD(load_l), .DATAIN(datain_l), .READY(ready_l),
    .SOUT(sout_l), .SVALID(svalid_l), .SREADY(sready_l), .DONE(done_l)
  );

  always @(negedge CLOCK) if (DONE) done_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge CLOCK);
  endtask

  // Sends one word on the MSB-first instance, collecting accepted bits.
  // stall: SREADY follows 1,0,0 repeating. inject: LOAD pulse mid-frame.
  task automatic run_word(input string tag, input logic [15:0] d, input bit stall, input bit inject);
    logic [15:0] got;
    int beats, k, svalid_bad, hold_bad;
    logic prev_stall, prev_bit;
    got = '0; beats = 0; svalid_bad = 0; hold_bad = 0;
    prev_stall = 1'b0; prev_bit = 1'b0;
    check({tag, " ready_before"}, READY, 1);
    LOAD = 1'b1; DATAIN = d; SREADY = 1'b0;
    step;
    LOAD = 1'b0; DATAIN = ~d;
    k = 0;
    while (!DONE && k < 200) begin
      if (!SVALID) svalid_bad++;
      if (prev_stall && (SOUT !== prev_bit)) hold_bad++;
      SREADY = stall ? (k % 3 == 0) : 1'b1;
      if (inject && k == 4) begin
        LOAD = 1'b1; DATAIN = 16'h323E;
      end else begin
        LOAD = 1'b0;
      end
      if (SVALID && SREADY) begin
        got = {got[14:0], SOUT};
        beats++;
      end
      prev_stall = !SREADY;
      prev_bit = SOUT;
      step;
      k++;
    end
    LOAD = 1'b0; SREADY = 1'b1;
    check({tag, " word"}, got, d);
    check({tag, " beats"}, beats, 16);
    check({tag, " svalid_gap"}, svalid_bad, 0);
    check({tag, " stall_hold"}, hold_bad, 0);
    check({tag, " latency"}, k, stall ? 46 : 16);
    check({tag, " done"}, DONE, 1);
    check({tag, " svalid_at_done"}, SVALID, 0);
    check({tag, " sout_at_done"}, SOUT, 0);
    check({tag, " ready_at_done"}, READY, 0);
    step;
    check({tag, " done_clear"}, DONE, 0);
    check({tag, " ready_after"}, READY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got_l;
    int k, beats, base;

    RESET = 1'b1; LOAD = 1'b0; SREADY = 1'b0; DATAIN = '0;
    load_l = 1'b0; sready_l = 1'b0; datain_l = '0;
    step;
    check("rst ready", READY, 1);
    check("rst svalid", SVALID, 0);
    check("rst sout", SOUT, 0);
    check("rst done", DONE, 0);
    check("rst lsb ready", ready_l, 1);
    RESET = 1'b0;
    step;
    check("idle ready", READY, 1);
    check("idle svalid", SVALID, 0);

    // 1: full rate, MSB first
    run_word("t1", 16'h64C2, 1'b0, 1'b0);
    // 2: SREADY stalls
    run_word("t2", 16'h424C, 1'b1, 1'b0);
    // 3: LOAD mid-frame ignored, then next word
    run_word("t3", 16'hA5C3, 1'b0, 1'b1);
    run_word("t3b", 16'h323E, 1'b0, 1'b0);

    // 4: LSB first, single set bit
    check("t4 ready", ready_l, 1);
    load_l = 1'b1; datain_l = 16'h0001; sready_l = 1'b1;
    step;
    load_l = 1'b0; datain_l = 16'hFFFF;
    check("t4 first_bit", sout_l, 1);
    got_l = '0; k = 0; beats = 0;
    while (!done_l && k < 100) begin
      if (svalid_l) begin
        got_l = {sout_l, got_l[15:1]};
        beats++;
      end
      step;
      k++;
    end
    check("t4 word", got_l, 16'h0001);
    check("t4 beats", beats, 16);
    check("t4 latency", k, 16);
    check("t4 done", done_l, 1);
    step;
    check("t4 done_clear", done_l, 0);
    check("t4 ready_after", ready_l, 1);

    // 5: reset mid-frame, LOAD together with RESET
    base = done_pulses;
    LOAD = 1'b1; DATAIN = 16'hFFFF; SREADY = 1'b1;
    step;
    LOAD = 1'b0;
    repeat (5) step;
    check("t5 mid svalid", SVALID, 1);
    check("t5 mid sout", SOUT, 1);
    RESET = 1'b1; LOAD = 1'b1;
    step;
    check("t5 ready", READY, 1);
    check("t5 svalid", SVALID, 0);
    check("t5 sout", SOUT, 0);
    check("t5 done", DONE, 0);
    step;
    check("t5 load_in_reset ready", READY, 1);
    check("t5 load_in_reset svalid", SVALID, 0);
    RESET = 1'b0; LOAD = 1'b0;
    step;
    check("t5 post ready", READY, 1);
    check("t5 post svalid", SVALID, 0);
    check("t5 no_done", done_pulses - base, 0);

    // 6: back-to-back words
    base = done_pulses;
    run_word("t6a", 16'hAAAA, 1'b0, 1'b0);
    run_word("t6b", 16'h5555, 1'b0, 1'b0);
    check("t6 done_pulses", done_pulses - base, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_serializer.md
Name: register_serializer

Overview:
Parallel-in, serial-out transmitter for 16-bit datapath words. It is the read-out side of a load-enabled datapath register: it captures a word on LOAD and shifts it out one bit per accepted beat over a valid/ready serial link. It signals completion with a one-cycle DONE pulse. It sits between the register bank and any bit-serial consumer, such as a debug or output port.

Parameters:
WIDTH, 16, word width in bits; legal values are WIDTH >= 2.
MSB_FIRST, 1, 1 shifts DATAIN[WIDTH-1] first; 0 shifts DATAIN[0] first.

Ports:
CLOCK  input  1  system clock; all state changes on the rising edge.
RESET  input  1  synchronous, active-high reset.
LOAD  input  1  parallel-load request; accepted only when READY=1.
DATAIN  input  WIDTH  word to transmit; sampled on the accepting edge only.
READY  output  1  block is idle and can accept LOAD.
SOUT  output  1  current serial bit; registered.
SVALID  output  1  SOUT holds a valid bit.
SREADY  input  1  consumer accepts the current bit.
DONE  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- One clock domain (CLOCK). RESET is synchronous and active-high. There is no other reset path.
- Reset values: state=IDLE, shift register=0, bit counter=0, READY=1, SOUT=0, SVALID=0, DONE=0.
- RESET has priority over every other input in the same cycle, including LOAD and SREADY.
- Internal state: WIDTH-bit shift register, plus a bit counter of width $clog2(WIDTH+1).
- IDLE state:
  - Outputs are READY=1, SVALID=0, DONE=0, SOUT=0.
  - At an edge with LOAD=1: capture DATAIN, clear the counter, go to SHIFT.
  - After that edge: READY=0, SVALID=1, SOUT = first bit (DATAIN[WIDTH-1] if MSB_FIRST, else DATAIN[0]).
- SHIFT state, beat rules:
  - A beat occurs at an edge with SVALID=1 and SREADY=1.
  - On a beat: shift toward the output end (left if MSB_FIRST, else right), fill with 0, increment the counter. SOUT shows the next bit after the edge.
  - SREADY=0 stalls: SOUT, SVALID and the counter hold indefinitely.
- SHIFT state, exit:
  - The beat that accepts bit WIDTH-1 (counter reaches WIDTH) moves to DONE.
  - After that edge: SVALID=0, SOUT=0, DONE=1, READY=0.
- DONE state: lasts exactly one cycle. Next edge goes to IDLE; after it, DONE=0 and READY=1.
- Latency: with SREADY held at 1, LOAD accept to DONE pulse takes WIDTH+1 edges; READY is high again after WIDTH+2 edges.
- LOAD while READY=0 (SHIFT or DONE) is ignored; the in-flight word is never corrupted.
- DATAIN changes after capture have no effect.
- RESET mid-frame aborts the word: no DONE pulse, outputs return to reset values on the next edge.
- SREADY is ignored while SVALID=0. Outputs are fully registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then LOAD=1 with DATAIN=16'h64C2, MSB_FIRST=1, SREADY=1 -> SOUT over the 16 beats is 0110 0100 1100 0010, SVALID=1 throughout. DONE=1 exactly one cycle after the 16th beat. READY=1 on the following cycle.
2. DATAIN=16'h424C with SREADY toggling 1,0,0,1,... -> each bit is held stable while SREADY=0. Serial sequence matches 0100 0010 0100 1100. DONE appears only after 16 accepted beats.
3. During SHIFT, pulse LOAD with DATAIN=16'h323E -> ignored. The original word completes unchanged. A new LOAD after READY=1 transmits 0011 0010 0011 1110.
4. MSB_FIRST=0, DATAIN=16'h0001, SREADY=1 -> first SOUT=1, the next 15 bits are 0, then a DONE pulse.
5. Assert RESET after 5 beats of 16'hFFFF -> next cycle READY=1, SVALID=0, SOUT=0, and no DONE pulse. LOAD together with RESET is also ignored.
6. Back-to-back words 16'hAAAA then 16'h5555, each LOAD issued the first cycle READY=1 -> no bit lost or duplicated, and exactly two DONE pulses.
